// File: rtl/stream_merge_2to1.sv
// Two-input round-robin stream merge with a single registered output stage.
// Optional STREAM_MERGE_SRC_ID_EN adds out_id, the source index of the buffered beat.
module stream_merge_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef STREAM_MERGE_SRC_ID_EN
  output logic             out_id,
`endif
  input  logic             out_ready
);

  logic accept;
  logic grant0;
  logic grant1;
  logic xfer;
  logic last;

  // last is the index served most recently; the other input wins a contested cycle
  always_comb begin
    accept = !out_valid || out_ready;
    grant0 = in0_valid && (!in1_valid || last);
    grant1 = in1_valid && (!in0_valid || !last);
    // readys are gated by rst_n so no handshake can complete while reset is held
    in0_ready = rst_n && accept && grant0;
    in1_ready = rst_n && accept && grant1;
    xfer = in0_ready || in1_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last      <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in1_ready ? in1_data : in0_data;
      last      <= in1_ready;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MERGE_SRC_ID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_id <= 1'b0;
    end else if (xfer) begin
      out_id <= in1_ready;
    end
  end
`endif

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Directed bench for stream_merge_2to1: arbitration order, stall hold, reset behaviour.
// Checks out_id as well when built with STREAM_MERGE_SRC_ID_EN.
module tb_stream_merge_2to1;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef STREAM_MERGE_SRC_ID_EN
  logic             out_id;
`endif

  int n_cmp;
  int n_err;

  stream_merge_2to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef STREAM_MERGE_SRC_ID_EN
    .out_id    (out_id),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; check readys mid-cycle, then the registered output after the edge.
  task automatic cycle_chk(input string tag, input logic [1:0] exp_rdy, input logic exp_valid,
                           input logic [WIDTH-1:0] exp_data, input logic exp_id);
    #1;
    check_val({tag, " ready"}, {30'd0, in1_ready, in0_ready}, {30'd0, exp_rdy});
    @(posedge clk);
    #1;
    check_val({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check_val({tag, " out_data"}, {24'd0, out_data}, {24'd0, exp_data});
`ifdef STREAM_MERGE_SRC_ID_EN
      check_val({tag, " out_id"}, {31'd0, out_id}, {31'd0, exp_id});
`endif
    end
  endtask

  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic ord);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ord;
  endtask

  logic [1:0] req_tab   [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] grant_tab [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held with traffic offered: nothing may be accepted
    rst_n = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    #3;
    check_val("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst out_data", {24'd0, out_data}, 32'd0);
    check_val("rst ready", {30'd0, in1_ready, in0_ready}, 32'd0);
`ifdef STREAM_MERGE_SRC_ID_EN
    check_val("rst out_id", {31'd0, out_id}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Contested 11 traffic alternates starting with src0
    cycle_chk("alt0", 2'b01, 1'b1, 8'h11, 1'b0);
    cycle_chk("alt1", 2'b10, 1'b1, 8'h22, 1'b1);
    cycle_chk("alt2", 2'b01, 1'b1, 8'h11, 1'b0);
    cycle_chk("alt3", 2'b10, 1'b1, 8'h22, 1'b1);

    // Request pattern table
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] ed;
      ed = (grant_tab[i] == 2'b01) ? WIDTH'(8'hA0 + i) : WIDTH'(8'hB0 + i);
      drive(req_tab[i][0], WIDTH'(8'hA0 + i), req_tab[i][1], WIDTH'(8'hB0 + i), 1'b1);
      cycle_chk($sformatf("pat%0d", i), grant_tab[i], grant_tab[i] != 2'b00, ed, grant_tab[i][1]);
    end

    // Stall: buffered 0x5A must hold with both readys low, then refill with no bubble
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    cycle_chk("load5a", 2'b01, 1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    for (int k = 0; k < 3; k++)
      cycle_chk($sformatf("stall%0d", k), 2'b00, 1'b1, 8'h5A, 1'b0);
    out_ready = 1'b1;
    cycle_chk("unstall", 2'b10, 1'b1, 8'h44, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle_chk("drain", 2'b00, 1'b0, 8'h00, 1'b0);

    // Only in1 for 4 beats, then in0 wins the first contested cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, WIDTH'(8'hC0 + k), 1'b1);
      cycle_chk($sformatf("solo1_%0d", k), 2'b10, 1'b1, WIDTH'(8'hC0 + k), 1'b1);
    end
    drive(1'b1, 8'hD0, 1'b1, 8'hE0, 1'b1);
    cycle_chk("contest", 2'b01, 1'b1, 8'hD0, 1'b0);

    // Reset during a stall: output clears without an edge, src0 served first afterwards
    out_ready = 1'b0;
    cycle_chk("prerst", 2'b00, 1'b1, 8'hD0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst out_data", {24'd0, out_data}, 32'd0);
    check_val("midrst ready", {30'd0, in1_ready, in0_ready}, 32'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cycle_chk("postrst0", 2'b01, 1'b1, 8'h11, 1'b0);
    cycle_chk("postrst1", 2'b10, 1'b1, 8'h22, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
